// File: rtl/adder_arb2_pkg.sv
// adder_arb2 shared definitions: FSM state encoding,
// default datapath width and requester id constants.
package adder_arb2_pkg;

    localparam int WIDTH_DEF = 4;

    localparam logic ID0 = 1'b0;
    localparam logic ID1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/adder_ripple.sv
// adder_ripple: shared ripple-carry adder, carry-out discarded.
// Ports: a_i, b_i operands in; sum_o = (a_i + b_i) mod 2^WIDTH.
module adder_ripple
    import adder_arb2_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o
);

    // c[i] is the carry into bit i; the final carry-out is never formed.
    logic [WIDTH-1:0] c;

    always_comb begin
        c = '0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            c[i+1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign sum_o = a_i ^ b_i ^ c;

endmodule

// File: rtl/adder_arb2.sv
// adder_arb2: two-requester arbiter/sequencer for one shared adder.
// Ports: clk, rst (async, active high); req0/a0/b0/ack0 and
// req1/a1/b1/ack1 requester ports; out_valid/out_ready/out_sum/out_id
// result port. Define ADDER_ARB2_RR_EN for round-robin tie-break,
// otherwise requester 0 wins every tie.
module adder_arb2
    import adder_arb2_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_id
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             grant_q, grant_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             id_q, id_d;
    logic             valid_q, valid_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic [WIDTH-1:0] sum_w;
    logic             cap;
    logic             tie_win;
    logic             win;

    adder_ripple #(.WIDTH(WIDTH)) u_add (
        .a_i   (op_a_q),
        .b_i   (op_b_q),
        .sum_o (sum_w)
    );

`ifdef ADDER_ARB2_RR_EN
    logic last_q, last_d;

    // Tie goes to whoever was not captured last.
    assign tie_win = ~last_q;

    always_comb begin
        last_d = last_q;
        if (cap) begin
            last_d = win;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= ID1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign tie_win = ID0;
`endif

    // A lone request wins outright; only a tie consults the policy.
    assign win = (req0 && req1) ? tie_win : req1;

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        grant_d = grant_q;
        sum_d   = sum_q;
        id_d    = id_q;
        valid_d = valid_q;
        cap     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    cap     = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                sum_d   = sum_w;
                id_d    = grant_q;
                valid_d = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                // The handshake edge may also capture the next request.
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (req0 || req1) begin
                        cap     = 1'b1;
                        state_d = CALC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (cap) begin
            op_a_d  = win ? a1 : a0;
            op_b_d  = win ? b1 : b0;
            grant_d = win;
        end
        ack0_d = cap && (win == ID0);
        ack1_d = cap && (win == ID1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            grant_q <= ID0;
            sum_q   <= '0;
            id_q    <= ID0;
            valid_q <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            grant_q <= grant_d;
            sum_q   <= sum_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_id    = id_q;

endmodule

// File: tb/tb_adder_arb2.sv
// Self-checking bench for adder_arb2: directed vectors, multi-cycle
// corner sequences and a randomized run against a scoreboard model.
module tb_adder_arb2;

    logic       clk;
    logic       rst;
    logic       req0, req1;
    logic [3:0] a0, b0, a1, b1;
    logic       ack0, ack1;
    logic       out_valid, out_ready;
    logic [3:0] out_sum;
    logic       out_id;

    int total;
    int bad;

    adder_arb2 dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .a0        (a0),
        .b0        (b0),
        .ack0      (ack0),
        .req1      (req1),
        .a1        (a1),
        .b1        (b1),
        .ack1      (ack1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_id    (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       who;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp_sum;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_single(input logic who, input logic [3:0] a,
                              input logic [3:0] b, input logic [3:0] es);
        out_ready = 1'b1;
        if (who) begin
            req1 = 1'b1; a1 = a; b1 = b;
        end else begin
            req0 = 1'b1; a0 = a; b0 = b;
        end
        tick();
        check("single_ack", {ack1, ack0}, who ? 2'b10 : 2'b01);
        check("single_nv", out_valid, 0);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        check("single_res", {out_valid, out_id, out_sum},
              {1'b1, who, es});
        check("single_noack", {ack1, ack0}, 0);
        tick();
        check("single_clr", out_valid, 0);
    endtask

    logic [4:0] q[$];
    logic [4:0] expv;
    logic       p_r0, p_r1, p_hs, p_valid, p_id;
    logic [3:0] p_a0, p_b0, p_a1, p_b1, p_sum;
    logic       rr_last;
    logic       exp_win;
    logic       raising;
    int         w0, w1, n, acks1, got;
    logic       ids[4];
    logic [3:0] sums[4];

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req0  = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        out_ready = 1'b1;
        vecs[0] = '{1'b0, 4'd3,  4'd5,  4'd8};
        vecs[1] = '{1'b1, 4'd15, 4'd1,  4'd0};
        vecs[2] = '{1'b0, 4'd15, 4'd15, 4'd14};
        vecs[3] = '{1'b1, 4'd9,  4'd8,  4'd1};
        vecs[4] = '{1'b0, 4'd0,  4'd0,  4'd0};
        vecs[5] = '{1'b1, 4'd10, 4'd6,  4'd0};

        tick();
        tick();
        check("reset_vals", {out_valid, out_id, out_sum, ack0, ack1}, 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_single(vecs[i].who, vecs[i].a, vecs[i].b, vecs[i].exp_sum);
        end

        // Tie with both requests held and no backpressure.
        do_reset();
        out_ready = 1'b1;
        req0 = 1'b1; a0 = 4'd2; b0 = 4'd2;
        req1 = 1'b1; a1 = 4'd7; b1 = 4'd1;
        n = 0;
        acks1 = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            p_hs  = out_valid && out_ready;
            p_id  = out_id;
            p_sum = out_sum;
            tick();
            if (ack1) acks1++;
            if (p_hs) begin
                ids[n]  = p_id;
                sums[n] = p_sum;
                n++;
            end
        end
        check("tie_count", n, 4);
        for (int i = 0; i < n; i++) begin
`ifdef ADDER_ARB2_RR_EN
            exp_win = (i % 2 == 1);
`else
            exp_win = 1'b0;
`endif
            check("tie_id", ids[i], exp_win);
            check("tie_sum", sums[i], exp_win ? 4'd8 : 4'd4);
        end
`ifndef ADDER_ARB2_RR_EN
        check("tie_no_ack1", acks1, 0);
`endif
        req0 = 1'b0;
        got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            tick();
            if (ack1) got = 1;
        end
        check("tie_ack1_after_drop", got, 1);
        req1 = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        check("tie_drained", out_valid, 0);

        // Backpressure with a pending request.
        req0 = 1'b1; a0 = 4'd4; b0 = 4'd4;
        out_ready = 1'b0;
        tick();
        check("bp_ack0", ack0, 1);
        req0 = 1'b0;
        tick();
        req1 = 1'b1; a1 = 4'd1; b1 = 4'd2;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold", {out_valid, out_id, out_sum}, {1'b1, 1'b0, 4'd8});
            check("bp_noack", {ack1, ack0}, 0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_hs_ack1", {ack1, ack0}, 2'b10);
        check("bp_hs_clr", out_valid, 0);
        req1 = 1'b0;
        tick();
        check("bp_next", {out_valid, out_id, out_sum}, {1'b1, 1'b1, 4'd3});
        tick();
        check("bp_idle", out_valid, 0);

        // Reset during CALC.
        req0 = 1'b1; a0 = 4'd5; b0 = 4'd5;
        tick();
        check("rc_ack0", ack0, 1);
        req0 = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rc_async", {out_valid, out_sum, out_id, ack0, ack1}, 0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rc_quiet", {out_valid, ack0, ack1}, 0);
        end
        run_single(1'b0, 4'd1, 4'd1, 4'd2);

        // Randomized run against a scoreboard.
        do_reset();
        q.delete();
        rr_last = 1'b1;
        w0 = 0;
        w1 = 0;
        for (int cyc = 0; cyc < 2400; cyc++) begin
            raising = (cyc < 2000);
            if (!raising && !req0 && !req1 && !out_valid && q.size() == 0)
                break;
            p_r0 = req0; p_r1 = req1;
            p_a0 = a0; p_b0 = b0; p_a1 = a1; p_b1 = b1;
            p_hs = out_valid && out_ready;
            p_valid = out_valid;
            p_id = out_id;
            p_sum = out_sum;
            tick();
            if (p_hs) begin
                if (q.size() == 0) begin
                    check("rnd_unexpected", {p_id, p_sum}, 5'h1f ^ {p_id, p_sum});
                end else begin
                    expv = q.pop_front();
                    check("rnd_result", {p_id, p_sum}, expv);
                end
            end else if (p_valid) begin
                check("rnd_hold", {out_valid, out_id, out_sum},
                      {1'b1, p_id, p_sum});
            end
            if (ack0 || ack1) begin
                check("rnd_ack_excl", {ack1, ack0} == 2'b11, 0);
                exp_win = ack1;
                if (p_r0 && p_r1) begin
`ifdef ADDER_ARB2_RR_EN
                    exp_win = ~rr_last;
`else
                    exp_win = 1'b0;
`endif
                end
                check("rnd_ack_who", ack1, exp_win);
                check("rnd_ack_req", ack1 ? p_r1 : p_r0, 1);
                rr_last = ack1;
                if (ack1) q.push_back({1'b1, 4'(p_a1 + p_b1)});
                else      q.push_back({1'b0, 4'(p_a0 + p_b0)});
            end
            w0 = (req0 && !ack0) ? w0 + 1 : 0;
            w1 = (req1 && !ack1) ? w1 + 1 : 0;
            if (w0 > 300 || w1 > 300) begin
                check("rnd_starve", 1, 0);
                break;
            end
            if (ack0) begin
                if ($urandom_range(1, 0) == 0) req0 = 1'b0;
                else begin a0 = 4'($urandom); b0 = 4'($urandom); end
                if (!raising) req0 = 1'b0;
            end else if (!req0 && raising && $urandom_range(2, 0) == 0) begin
                req0 = 1'b1; a0 = 4'($urandom); b0 = 4'($urandom);
            end
            if (ack1) begin
                if ($urandom_range(1, 0) == 0) req1 = 1'b0;
                else begin a1 = 4'($urandom); b1 = 4'($urandom); end
                if (!raising) req1 = 1'b0;
            end else if (!req1 && raising && $urandom_range(2, 0) == 0) begin
                req1 = 1'b1; a1 = 4'($urandom); b1 = 4'($urandom);
            end
            out_ready = raising ? ($urandom_range(3, 0) != 0) : 1'b1;
        end
        check("rnd_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
